io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
- Device-side endpoint of the processor's port interface.
- Captures words the core emits on its output port and queues them for an external consumer over a valid/ready link.
- Accepts words from an external producer over a valid/ready link and presents them on the core's input port.
- Raises the core's interrupt line when input data is pending, and holds it until the core acknowledges.

Parameters:
DATA_W, 16, port word width (matches the core's 16-bit ports)
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)
IN_DEPTH, 4, input FIFO entries (power of 2, >=2)
INT_THRESH, 1, input FIFO occupancy that raises an interrupt (1..IN_DEPTH)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
cpu_out_data  input  DATA_W  core output-port value
cpu_out_we  input  1  one-cycle strobe: an OUT instruction is writing cpu_out_data
cpu_in_data  output  DATA_W  value driven onto the core input port
cpu_in_re  input  1  one-cycle strobe: an IN instruction consumed cpu_in_data
intr  output  1  interrupt request to the core
intr_en  input  1  interrupt enable
intr_ack  input  1  core acknowledges the interrupt (one cycle)
ext_tx_data  output  DATA_W  word to the external consumer
ext_tx_valid  output  1  ext_tx_data is valid
ext_tx_ready  input  1  external consumer accepts
ext_rx_data  input  DATA_W  word from the external producer
ext_rx_valid  input  1  ext_rx_data is valid
ext_rx_ready  output  1  responder can accept
out_count  output  log2(OUT_DEPTH)+1  output FIFO occupancy
in_count  output  log2(IN_DEPTH)+1  input FIFO occupancy
out_ovf  output  1  sticky: a cpu_out_we was dropped
in_unf  output  1  sticky: cpu_in_re arrived while the input FIFO was empty
err_clr  input  1  clears out_ovf and in_unf

Behaviour:
- Reset (rst=0, asynchronous): both FIFOs empty, pointers 0, out_count=0, in_count=0, ext_tx_valid=0, ext_rx_ready=1, intr=0, out_ovf=0, in_unf=0, interrupt FSM in IDLE. Data outputs read as 0. Reset mid-transfer discards all queued words.
- Output path (core to external):
  - Push when cpu_out_we=1 and (out not full, or a pop occurs in the same cycle).
  - A cpu_out_we on a full FIFO with no pop drops the word and sets out_ovf.
  - Pop when ext_tx_valid && ext_tx_ready.
  - ext_tx_valid = (out_count != 0). ext_tx_data = head entry, 0 when empty.
  - Latency: cpu_out_we at edge N gives ext_tx_valid=1 after edge N (no combinational path from cpu_out_we to ext_tx_valid).
  - ext_tx_data must stay stable while ext_tx_valid=1 and ext_tx_ready=0.
- Input path (external to core):
  - ext_rx_ready = (in_count != IN_DEPTH). This is registered-state based and has no dependency on cpu_in_re.
  - Push when ext_rx_valid && ext_rx_ready.
  - Pop when cpu_in_re=1 and in_count != 0.
  - cpu_in_re on an empty FIFO sets in_unf and changes nothing else.
  - cpu_in_data = head entry, 0 when empty. A pushed word appears on cpu_in_data one cycle after the accepting edge.
- Simultaneous push and pop on either FIFO: count unchanged, both pointers advance modulo depth. Pointers wrap at depth-1 to 0.
- Sticky flags: err_clr clears both flags. If a set event and err_clr occur in the same cycle, the set wins.
- Interrupt FSM:
  - IDLE (intr=0): if intr_en && in_count >= INT_THRESH, go to PEND.
  - PEND (intr=1): intr_ack goes to SERVICE. If intr_en drops, go to IDLE.
  - SERVICE (intr=0): when in_count==0, go to IDLE. New arrivals during SERVICE do not re-raise intr; the core is expected to drain the FIFO.
  - intr is a registered FSM output. It asserts one cycle after the threshold is reached.
  - intr_ack outside PEND is ignored.
- Counts are updated on the clock edge. out_count and in_count are pure registers.

Test Plan:
- Reset mid-traffic: load 3 output words, pull rst low for a partial cycle -> out_count=0, ext_tx_valid=0, intr=0, ext_rx_ready=1 immediately, before the next clock edge.
- Output FIFO: hold ext_tx_ready=0 and write 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 -> out_count=4, out_ovf=1. Then raise ready -> ext_tx_data sequence 0x1111..0x4444, ext_tx_valid=0 after the 4th.
- Full-plus-simultaneous: with the output FIFO full, cpu_out_we=1 (0xAAAA) and ext_tx_ready=1 in the same cycle -> 0xAAAA accepted, out_ovf unchanged, out_count stays 4.
- Input path and wrap: push 6 words 0x0001..0x0006, popping after each -> cpu_in_data returns them in order across the pointer wrap. A cpu_in_re while empty -> in_unf=1, cleared by err_clr.
- Interrupt: intr_en=1, INT_THRESH=1, push 0xBEEF -> intr=1 the next cycle. intr_ack -> intr=0. Push 0xCAFE before draining -> intr stays 0. Drain both -> FSM in IDLE. Next push -> intr=1 again.
- Backpressure: fill the input FIFO with 4 words -> ext_rx_ready=0, and a 5th ext_rx_valid is not accepted. One cpu_in_re -> ext_rx_ready=1 on the following cycle.

Source files
------------

// File: rtl/io_port_responder_if.sv
// Port-interface bundle between the core/external world and io_port_responder.
// The slave modport is the responder's view; master is the view of whatever
// drives the core ports and the external links.
interface io_port_responder_if #(
  parameter int DATA_W    = 16,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
);
  localparam int OCW = $clog2(OUT_DEPTH) + 1;
  localparam int ICW = $clog2(IN_DEPTH) + 1;

  // Core output port (OUT instruction)
  logic [DATA_W-1:0] cpu_out_data;
  logic              cpu_out_we;
  // Core input port (IN instruction)
  logic [DATA_W-1:0] cpu_in_data;
  logic              cpu_in_re;
  // Interrupt handshake
  logic              intr;
  logic              intr_en;
  logic              intr_ack;
  // External consumer link
  logic [DATA_W-1:0] ext_tx_data;
  logic              ext_tx_valid;
  logic              ext_tx_ready;
  // External producer link
  logic [DATA_W-1:0] ext_rx_data;
  logic              ext_rx_valid;
  logic              ext_rx_ready;
  // Status
  logic [OCW-1:0]    out_count;
  logic [ICW-1:0]    in_count;
  logic              out_ovf;
  logic              in_unf;
  logic              err_clr;

  modport slave (
    input  cpu_out_data, cpu_out_we, cpu_in_re, intr_en, intr_ack,
           ext_tx_ready, ext_rx_data, ext_rx_valid, err_clr,
    output cpu_in_data, intr, ext_tx_data, ext_tx_valid, ext_rx_ready,
           out_count, in_count, out_ovf, in_unf
  );

  modport master (
    output cpu_out_data, cpu_out_we, cpu_in_re, intr_en, intr_ack,
           ext_tx_ready, ext_rx_data, ext_rx_valid, err_clr,
    input  cpu_in_data, intr, ext_tx_data, ext_tx_valid, ext_rx_ready,
           out_count, in_count, out_ovf, in_unf
  );
endinterface

// File: rtl/io_port_responder.sv
// Device-side endpoint of the core's port interface: an output FIFO from the
// core to an external consumer, an input FIFO from an external producer to the
// core, sticky error flags, and an interrupt FSM driven by input occupancy.
// Heads are read combinationally so a pushed word is visible the cycle after
// the accepting edge; empty FIFOs present 0.
module io_port_responder #(
  parameter int DATA_W     = 16,
  parameter int OUT_DEPTH  = 4,
  parameter int IN_DEPTH   = 4,
  parameter int INT_THRESH = 1
) (
  input logic                clk,
  input logic                rst,
  io_port_responder_if.slave port
);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL  = (OAW+1)'(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL   = (IAW+1)'(IN_DEPTH);
  localparam logic [IAW:0] INT_LEVEL = (IAW+1)'(INT_THRESH);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SERVICE} intr_state_t;

  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [OAW-1:0]    out_wr_ptr_reg;
  logic [OAW-1:0]    out_rd_ptr_reg;
  logic [OAW:0]      out_count_reg;

  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  logic [IAW-1:0]    in_wr_ptr_reg;
  logic [IAW-1:0]    in_rd_ptr_reg;
  logic [IAW:0]      in_count_reg;

  logic              out_ovf_reg;
  logic              in_unf_reg;
  intr_state_t       intr_state_reg;
  logic              intr_reg;

  logic out_push, out_pop, out_drop;
  logic in_push, in_pop, in_miss;

  // A full output FIFO still accepts a write when the head leaves the same cycle.
  assign out_pop  = (out_count_reg != '0) && port.ext_tx_ready;
  assign out_push = port.cpu_out_we && ((out_count_reg != OUT_FULL) || out_pop);
  assign out_drop = port.cpu_out_we && !out_push;

  // Input readiness depends only on registered occupancy, never on cpu_in_re.
  assign in_push = port.ext_rx_valid && (in_count_reg != IN_FULL);
  assign in_pop  = port.cpu_in_re && (in_count_reg != '0);
  assign in_miss = port.cpu_in_re && (in_count_reg == '0);

  assign port.ext_tx_valid = (out_count_reg != '0);
  assign port.ext_tx_data  = (out_count_reg != '0) ? out_mem[out_rd_ptr_reg] : '0;
  assign port.ext_rx_ready = (in_count_reg != IN_FULL);
  assign port.cpu_in_data  = (in_count_reg != '0) ? in_mem[in_rd_ptr_reg] : '0;
  assign port.out_count    = out_count_reg;
  assign port.in_count     = in_count_reg;
  assign port.out_ovf      = out_ovf_reg;
  assign port.in_unf       = in_unf_reg;
  assign port.intr         = intr_reg;

  // Storage writes; contents need no reset because empty FIFOs mask the head.
  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr_reg] <= port.cpu_out_data;
    if (in_push)  in_mem[in_wr_ptr_reg]   <= port.ext_rx_data;
  end

  // Output FIFO pointers and occupancy; power-of-2 depth gives natural wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_count_reg  <= '0;
    end else begin
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + OAW'(1);
      if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + OAW'(1);
      if (out_push && !out_pop)      out_count_reg <= out_count_reg + (OAW+1)'(1);
      else if (!out_push && out_pop) out_count_reg <= out_count_reg - (OAW+1)'(1);
    end
  end

  // Input FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_ptr_reg <= '0;
      in_rd_ptr_reg <= '0;
      in_count_reg  <= '0;
    end else begin
      if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + IAW'(1);
      if (in_pop)  in_rd_ptr_reg <= in_rd_ptr_reg + IAW'(1);
      if (in_push && !in_pop)      in_count_reg <= in_count_reg + (IAW+1)'(1);
      else if (!in_push && in_pop) in_count_reg <= in_count_reg - (IAW+1)'(1);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_ovf_reg <= 1'b0;
      in_unf_reg  <= 1'b0;
    end else begin
      if (out_drop)          out_ovf_reg <= 1'b1;
      else if (port.err_clr) out_ovf_reg <= 1'b0;
      if (in_miss)           in_unf_reg  <= 1'b1;
      else if (port.err_clr) in_unf_reg  <= 1'b0;
    end
  end

  // Interrupt FSM: raise on occupancy, drop on ack, re-arm only once drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intr_state_reg <= ST_IDLE;
      intr_reg       <= 1'b0;
    end else begin
      case (intr_state_reg)
        ST_IDLE: begin
          if (port.intr_en && (in_count_reg >= INT_LEVEL)) begin
            intr_state_reg <= ST_PEND;
            intr_reg       <= 1'b1;
          end
        end
        ST_PEND: begin
          if (!port.intr_en) begin
            intr_state_reg <= ST_IDLE;
            intr_reg       <= 1'b0;
          end else if (port.intr_ack) begin
            intr_state_reg <= ST_SERVICE;
            intr_reg       <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (in_count_reg == '0) intr_state_reg <= ST_IDLE;
          intr_reg <= 1'b0;
        end
        default: begin
          intr_state_reg <= ST_IDLE;
          intr_reg       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: reset, output FIFO overflow and
// drain, full-with-pop acceptance, input wrap, underflow flag, interrupt
// sequencing and input backpressure.
module tb_io_port_responder;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  io_port_responder_if #(.DATA_W(16), .OUT_DEPTH(4), .IN_DEPTH(4)) port ();

  io_port_responder #(
    .DATA_W(16), .OUT_DEPTH(4), .IN_DEPTH(4), .INT_THRESH(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .port (port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_words [4];
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    port.cpu_out_data = '0; port.cpu_out_we = 1'b0; port.cpu_in_re = 1'b0;
    port.intr_en = 1'b0;    port.intr_ack = 1'b0;   port.ext_tx_ready = 1'b0;
    port.ext_rx_data = '0;  port.ext_rx_valid = 1'b0; port.err_clr = 1'b0;

    // Reset state
    #3;
    chk("rst_out_count", port.out_count, 0);
    chk("rst_in_count", port.in_count, 0);
    chk("rst_tx_valid", port.ext_tx_valid, 0);
    chk("rst_rx_ready", port.ext_rx_ready, 1);
    chk("rst_intr", port.intr, 0);
    chk("rst_flags", {port.out_ovf, port.in_unf}, 0);
    chk("rst_data", {port.ext_tx_data, port.cpu_in_data}, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Latency plus reset mid-traffic
    port.cpu_out_we = 1'b1; port.cpu_out_data = 16'h0D01;
    #1;
    chk("lat_no_comb_valid", port.ext_tx_valid, 0);
    tick();
    chk("lat_valid_after_edge", port.ext_tx_valid, 1);
    chk("lat_head", port.ext_tx_data, 16'h0D01);
    port.cpu_out_data = 16'h0D02; tick();
    port.cpu_out_data = 16'h0D03; tick();
    port.cpu_out_we = 1'b0;
    chk("mid_out_count", port.out_count, 3);
    rst = 1'b0;
    #2;
    chk("mid_rst_out_count", port.out_count, 0);
    chk("mid_rst_tx_valid", port.ext_tx_valid, 0);
    chk("mid_rst_intr", port.intr, 0);
    chk("mid_rst_rx_ready", port.ext_rx_ready, 1);
    chk("mid_rst_tx_data", port.ext_tx_data, 0);
    rst = 1'b1;
    tick();

    // Output overflow; the 5th write coincides with err_clr and the set wins
    exp_words[0] = 16'h1111; exp_words[1] = 16'h2222;
    exp_words[2] = 16'h3333; exp_words[3] = 16'h4444;
    port.ext_tx_ready = 1'b0;
    port.cpu_out_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      port.cpu_out_data = exp_words[i];
      tick();
    end
    chk("ovf_not_yet", port.out_ovf, 0);
    port.cpu_out_data = 16'h5555; port.err_clr = 1'b1;
    tick();
    port.cpu_out_we = 1'b0; port.err_clr = 1'b0;
    chk("ovf_count", port.out_count, 4);
    chk("ovf_flag_set_wins", port.out_ovf, 1);
    tick();
    chk("ovf_stable_head", port.ext_tx_data, 16'h1111);
    port.ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid_%0d", i), port.ext_tx_valid, 1);
      chk($sformatf("drain_data_%0d", i), port.ext_tx_data, exp_words[i]);
      tick();
    end
    chk("drain_empty_valid", port.ext_tx_valid, 0);
    chk("drain_empty_data", port.ext_tx_data, 0);
    port.err_clr = 1'b1; tick(); port.err_clr = 1'b0;
    chk("ovf_cleared", port.out_ovf, 0);

    // Full FIFO with simultaneous write and pop
    port.ext_tx_ready = 1'b0;
    port.cpu_out_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      port.cpu_out_data = 16'h0A01 + 16'(i);
      tick();
    end
    port.cpu_out_data = 16'hAAAA; port.ext_tx_ready = 1'b1;
    tick();
    port.cpu_out_we = 1'b0;
    chk("full_sim_count", port.out_count, 4);
    chk("full_sim_ovf", port.out_ovf, 0);
    exp_words[0] = 16'h0A02; exp_words[1] = 16'h0A03;
    exp_words[2] = 16'h0A04; exp_words[3] = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_sim_data_%0d", i), port.ext_tx_data, exp_words[i]);
      tick();
    end
    chk("full_sim_empty", port.out_count, 0);
    port.ext_tx_ready = 1'b0;

    // Input path across the pointer wrap
    for (int i = 1; i <= 6; i++) begin
      port.ext_rx_valid = 1'b1; port.ext_rx_data = 16'(i);
      tick();
      port.ext_rx_valid = 1'b0;
      chk($sformatf("in_data_%0d", i), port.cpu_in_data, i);
      chk($sformatf("in_count1_%0d", i), port.in_count, 1);
      port.cpu_in_re = 1'b1;
      tick();
      port.cpu_in_re = 1'b0;
      chk($sformatf("in_count0_%0d", i), port.in_count, 0);
      chk($sformatf("in_empty_data_%0d", i), port.cpu_in_data, 0);
    end
    chk("in_no_intr_disabled", port.intr, 0);
    port.cpu_in_re = 1'b1; tick(); port.cpu_in_re = 1'b0;
    chk("unf_set", port.in_unf, 1);
    chk("unf_count", port.in_count, 0);
    port.err_clr = 1'b1; tick(); port.err_clr = 1'b0;
    chk("unf_cleared", port.in_unf, 0);

    // Interrupt sequencing
    port.intr_en = 1'b1;
    port.ext_rx_valid = 1'b1; port.ext_rx_data = 16'hBEEF;
    tick();
    port.ext_rx_valid = 1'b0;
    chk("intr_not_yet", port.intr, 0);
    tick();
    chk("intr_raised", port.intr, 1);
    port.intr_ack = 1'b1; tick(); port.intr_ack = 1'b0;
    chk("intr_acked", port.intr, 0);
    port.ext_rx_valid = 1'b1; port.ext_rx_data = 16'hCAFE;
    tick();
    port.ext_rx_valid = 1'b0;
    tick();
    chk("intr_service_hold", port.intr, 0);
    chk("intr_service_count", port.in_count, 2);
    chk("intr_head_beef", port.cpu_in_data, 16'hBEEF);
    port.cpu_in_re = 1'b1; tick();
    chk("intr_head_cafe", port.cpu_in_data, 16'hCAFE);
    tick(); port.cpu_in_re = 1'b0;
    chk("intr_drained", port.in_count, 0);
    tick();
    chk("intr_idle", port.intr, 0);
    port.ext_rx_valid = 1'b1; port.ext_rx_data = 16'h1234;
    tick();
    port.ext_rx_valid = 1'b0;
    tick();
    chk("intr_reraised", port.intr, 1);
    port.intr_en = 1'b0; tick();
    chk("intr_en_drop", port.intr, 0);
    port.cpu_in_re = 1'b1; tick(); port.cpu_in_re = 1'b0;

    // Input backpressure
    port.ext_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      port.ext_rx_data = 16'h0101 + 16'(i);
      tick();
    end
    chk("bp_count_full", port.in_count, 4);
    chk("bp_not_ready", port.ext_rx_ready, 0);
    port.ext_rx_data = 16'h0105;
    tick();
    port.ext_rx_valid = 1'b0;
    chk("bp_5th_rejected", port.in_count, 4);
    chk("bp_head", port.cpu_in_data, 16'h0101);
    port.cpu_in_re = 1'b1;
    #1;
    chk("bp_ready_no_comb_re", port.ext_rx_ready, 0);
    tick();
    port.cpu_in_re = 1'b0;
    chk("bp_ready_after_pop", port.ext_rx_ready, 1);
    chk("bp_count_after_pop", port.in_count, 3);
    chk("bp_head_after_pop", port.cpu_in_data, 16'h0102);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
